// File: rtl/cp0_exc_unit.sv
// MIPS-style CP0 exception unit: Status/Cause/EPC/BadVAddr/Count/Compare,
// trap and ERET sequencing, and a registered pipeline-flush/redirect pulse.
module cp0_exc_unit #(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0040
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  input  logic                  pc_valid_i,
  output logic                  flush_o,
  output logic [31:0]           excaddr_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic [PW-1:0] presc;
  logic          eq_q;
  logic [7:0]    status_im;
  logic          status_exl;
  logic          status_ie;
  logic          cause_bd;
  logic          cause_ti;
  logic [1:0]    cause_ip_sw;
  logic [5:0]    hw_ip;
  logic [4:0]    cause_exccode;
  logic [31:0]   epc;
  logic          flush;
  logic [31:0]   excaddr;

  logic [5:0]    hw_vec;
  logic [7:0]    cause_ip;
  logic [31:0]   status_val;
  logic [31:0]   cause_val;
  logic          count_eq;
  logic          presc_wrap;
  logic          int_pending;
  logic          take_exc;
  logic          take_int;
  logic          take_trap;
  logic          take_eret;
  logic          do_mtc0;
  logic          wr_count;
  logic          wr_compare;
  logic          wr_status;
  logic          wr_cause;
  logic          wr_epc;

  always_comb begin
    hw_vec = '0;
    hw_vec[HW_INT_NUM-1:0] = hw_int_i;
  end

  // The timer shares IP7 with hardware line 5.
  assign cause_ip   = {hw_ip[5] | cause_ti, hw_ip[4:0], cause_ip_sw};
  assign status_val = {3'b000, 1'b1, 12'h000, status_im, 6'b00_0000, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'h0000, cause_ip, 1'b0, cause_exccode, 2'b00};

  assign count_eq   = (count == compare);
  assign presc_wrap = (presc == PRESC_LAST);

  // Exception beats interrupt beats ERET beats MTC0.
  always_comb begin
    int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));
    take_exc    = exc_valid_i;
    take_int    = ~exc_valid_i & pc_valid_i & int_pending;
    take_trap   = take_exc | take_int;
    take_eret   = eret_i & ~take_trap;
    do_mtc0     = we & ~take_trap & ~take_eret;
    wr_count    = do_mtc0 & (waddr == ADDR_COUNT);
    wr_compare  = do_mtc0 & (waddr == ADDR_COMPARE);
    wr_status   = do_mtc0 & (waddr == ADDR_STATUS);
    wr_cause    = do_mtc0 & (waddr == ADDR_CAUSE);
    wr_epc      = do_mtc0 & (waddr == ADDR_EPC);
  end

  // TI fires on a fresh Count/Compare match; eq_q starts high so the
  // zero/zero match out of reset does not count as one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      compare  <= '0;
      presc    <= '0;
      cause_ti <= 1'b0;
      eq_q     <= 1'b1;
    end else begin
      eq_q <= count_eq;
      if (wr_count) begin
        count <= wdata;
        presc <= '0;
      end else if (presc_wrap) begin
        count <= count + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (wr_compare) begin
        compare  <= wdata;
        cause_ti <= 1'b0;
      end else if (count_eq && !eq_q) begin
        cause_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hw_ip <= '0;
    end else begin
      hw_ip <= hw_vec;
    end
  end

  // A trap taken while already at EXL keeps the original return point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_im     <= '0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      epc           <= '0;
      badvaddr      <= '0;
    end else if (take_trap) begin
      if (!status_exl) begin
        epc      <= in_delay_i ? (pc_i - 32'd4) : pc_i;
        cause_bd <= in_delay_i;
      end
      status_exl    <= 1'b1;
      cause_exccode <= take_exc ? exccode_i : 5'h00;
      if (take_exc && (exccode_i == 5'h04 || exccode_i == 5'h05)) begin
        badvaddr <= badvaddr_i;
      end
    end else if (take_eret) begin
      status_exl <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im  <= wdata[15:8];
        status_exl <= wdata[1];
        status_ie  <= wdata[0];
      end
      if (wr_cause) begin
        cause_ip_sw <= wdata[9:8];
      end
      if (wr_epc) begin
        epc <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush   <= 1'b0;
      excaddr <= '0;
    end else begin
      flush <= take_trap | take_eret;
      if (take_exc) begin
        excaddr <= EXC_VECTOR;
      end else if (take_int) begin
        excaddr <= INT_VECTOR;
      end else if (take_eret) begin
        excaddr <= epc;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rst_n && re) begin
      case (raddr)
        ADDR_BADVADDR: rdata = badvaddr;
        ADDR_COUNT:    rdata = count;
        ADDR_COMPARE:  rdata = compare;
        ADDR_STATUS:   rdata = status_val;
        ADDR_CAUSE:    rdata = cause_val;
        ADDR_EPC:      rdata = epc;
        default:       rdata = '0;
      endcase
    end
  end

  assign flush_o     = flush;
  assign excaddr_o   = excaddr;
  assign status_o    = status_val;
  assign cause_o     = cause_val;
  assign epc_o       = epc;
  assign timer_int_o = cause_ti;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus randomized traffic, all
// checked against a register-image reference model of the CP0 rules.
module tb_cp0_exc_unit;

  localparam int COUNT_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [5:0]  hw_int_i = '0;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exccode_i = '0;
  logic [31:0] badvaddr_i = '0;
  logic        eret_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        in_delay_i = 1'b0;
  logic        pc_valid_i = 1'b0;
  logic        flush_o;
  logic [31:0] excaddr_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: full register images plus the timer bookkeeping.
  logic [31:0] m_status = 32'h1000_0000;
  logic [31:0] m_cause_sw = '0;
  logic [5:0]  m_hw = '0;
  logic        m_ti = 1'b0;
  logic [31:0] m_count = '0;
  logic [31:0] m_compare = '0;
  int          m_presc = 0;
  logic        m_prev_eq = 1'b1;
  logic [31:0] m_epc = '0;
  logic [31:0] m_badv = '0;
  logic        m_flush = 1'b0;
  logic [31:0] m_excaddr = '0;

  cp0_exc_unit #(
    .HW_INT_NUM(6),
    .COUNT_DIV(COUNT_DIV),
    .EXC_VECTOR(32'h0000_0100),
    .INT_VECTOR(32'h0000_0040)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .hw_int_i(hw_int_i),
    .exc_valid_i(exc_valid_i), .exccode_i(exccode_i), .badvaddr_i(badvaddr_i),
    .eret_i(eret_i), .pc_i(pc_i), .in_delay_i(in_delay_i), .pc_valid_i(pc_valid_i),
    .flush_o(flush_o), .excaddr_o(excaddr_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Cause = software image | sampled lines at IP2.. | TI at bit 30 and IP7.
  function automatic logic [31:0] model_cause();
    return m_cause_sw | (32'(m_hw) << 10) | (m_ti ? 32'h4000_8000 : 32'h0);
  endfunction

  function automatic logic [31:0] model_read();
    if (!rst_n || !re) return 32'h0;
    case (raddr)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return model_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelStep();
    logic [31:0] cause_now;
    logic pending, exc, intr, er, mtc0, now_eq;
    cause_now = model_cause();
    pending = m_status[0] && !m_status[1] && ((cause_now[15:8] & m_status[15:8]) != 8'h0);
    exc  = exc_valid_i;
    intr = !exc && pc_valid_i && pending;
    er   = eret_i && !exc && !intr;
    mtc0 = we && !exc && !intr && !er;
    now_eq = (m_count == m_compare);
    if (!rst_n) begin
      m_status = 32'h1000_0000; m_cause_sw = '0; m_hw = '0; m_ti = 1'b0;
      m_count = '0; m_compare = '0; m_presc = 0; m_epc = '0; m_badv = '0;
      m_flush = 1'b0; m_excaddr = '0;
      // The zero/zero match right after reset is not a new match.
      m_prev_eq = 1'b1;
      return;
    end
    if (mtc0 && waddr == 5'd9) begin
      m_count = wdata; m_presc = 0;
    end else if (m_presc == COUNT_DIV - 1) begin
      m_count = m_count + 32'd1; m_presc = 0;
    end else begin
      m_presc++;
    end
    if (mtc0 && waddr == 5'd11) begin
      m_compare = wdata; m_ti = 1'b0;
    end else if (now_eq && !m_prev_eq) begin
      m_ti = 1'b1;
    end
    m_prev_eq = now_eq;
    m_hw = hw_int_i;
    m_flush = exc || intr || er;
    if (exc || intr) begin
      if (!m_status[1]) begin
        m_epc = in_delay_i ? pc_i - 32'd4 : pc_i;
        m_cause_sw[31] = in_delay_i;
      end
      m_status[1] = 1'b1;
      m_cause_sw[6:2] = exc ? exccode_i : 5'd0;
      if (exc && (exccode_i == 5'h04 || exccode_i == 5'h05)) m_badv = badvaddr_i;
      m_excaddr = exc ? 32'h0000_0100 : 32'h0000_0040;
    end else if (er) begin
      m_excaddr = m_epc;
      m_status[1] = 1'b0;
    end else if (mtc0) begin
      case (waddr)
        5'd12: m_status = (wdata & 32'h0000_FF03) | 32'h1000_0000;
        5'd13: m_cause_sw[9:8] = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
    end
  endtask

  // One cycle: check the read port, clock, then check every state output.
  task automatic applyStimulus();
    #1;
    checkOutput("rdata", rdata, model_read());
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("status", status_o, m_status);
    checkOutput("cause", cause_o, model_cause());
    checkOutput("epc", epc_o, m_epc);
    checkOutput("timer_int", timer_int_o, m_ti);
    checkOutput("flush", flush_o, m_flush);
    checkOutput("excaddr", excaddr_o, m_excaddr);
  endtask

  task automatic clearInputs();
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
    hw_int_i = '0; exc_valid_i = 1'b0; exccode_i = '0; badvaddr_i = '0;
    eret_i = 1'b0; pc_i = '0; in_delay_i = 1'b0; pc_valid_i = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    applyStimulus();
    we = 1'b0;
  endtask

  function automatic logic [4:0] pickAddr();
    case ($urandom_range(0, 7))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic randomInputs();
    rst_n = ($urandom_range(0, 199) != 0);
    we = ($urandom_range(0, 3) == 0);
    waddr = pickAddr();
    wdata = $urandom;
    if (waddr == 5'd11) wdata = m_count + 32'($urandom_range(1, 20));
    if (waddr == 5'd9 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    re = $urandom_range(0, 1) == 1;
    raddr = pickAddr();
    hw_int_i = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h0;
    exc_valid_i = ($urandom_range(0, 19) == 0);
    case ($urandom_range(0, 2))
      0: exccode_i = 5'h04;
      1: exccode_i = 5'h05;
      default: exccode_i = 5'($urandom);
    endcase
    badvaddr_i = $urandom;
    eret_i = ($urandom_range(0, 14) == 0);
    pc_i = $urandom & 32'hFFFF_FFFC;
    in_delay_i = $urandom_range(0, 1) == 1;
    pc_valid_i = ($urandom_range(0, 4) != 0);
  endtask

  initial begin
    logic got;
    clearInputs();
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("reset_status", status_o, 32'h1000_0000);
    checkOutput("reset_flush", flush_o, 1'b0);
    rst_n = 1'b1;

    // Timer interrupt through IP7.
    writeReg(5'd12, 32'h0000_8001);
    writeReg(5'd11, 32'd5);
    pc_valid_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      applyStimulus();
      if (flush_o) got = 1'b1;
    end
    checkOutput("timer_irq_seen", got, 1'b1);
    checkOutput("timer_irq_vec", excaddr_o, 32'h0000_0040);
    checkOutput("timer_irq_code", cause_o[6:2], 5'h00);
    checkOutput("timer_irq_exl", status_o[1], 1'b1);

    // AdEL in a delay slot.
    pc_valid_i = 1'b0;
    writeReg(5'd12, 32'h0);
    exc_valid_i = 1'b1; exccode_i = 5'h04; badvaddr_i = 32'hDEAD_BEEF;
    pc_i = 32'h1000; in_delay_i = 1'b1;
    applyStimulus();
    checkOutput("adel_epc", epc_o, 32'h0000_0FFC);
    checkOutput("adel_bd", cause_o[31], 1'b1);
    checkOutput("adel_vec", excaddr_o, 32'h0000_0100);
    re = 1'b1; raddr = 5'd8;
    #1;
    checkOutput("adel_badvaddr", rdata, 32'hDEAD_BEEF);

    // Nested exception keeps EPC.
    exccode_i = 5'h0A; pc_i = 32'h2000; in_delay_i = 1'b0;
    applyStimulus();
    checkOutput("nested_epc", epc_o, 32'h0000_0FFC);
    checkOutput("nested_code", cause_o[6:2], 5'h0A);
    checkOutput("nested_flush", flush_o, 1'b1);
    exc_valid_i = 1'b0;

    // ERET wins over a same-cycle EPC write.
    eret_i = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'h1234;
    applyStimulus();
    eret_i = 1'b0; we = 1'b0;
    checkOutput("eret_target", excaddr_o, 32'h0000_0FFC);
    checkOutput("eret_epc", epc_o, 32'h0000_0FFC);
    checkOutput("eret_exl", status_o[1], 1'b0);

    // Write masks.
    writeReg(5'd12, 32'hFFFF_FFFF);
    checkOutput("status_mask", status_o, 32'h1000_FF03);
    writeReg(5'd13, 32'hFFFF_FFFF);
    checkOutput("cause_ip_sw", cause_o[9:8], 2'b11);
    checkOutput("cause_code_kept", cause_o[6:2], 5'h0A);
    writeReg(5'd12, 32'h0);

    // Count wraps.
    writeReg(5'd9, 32'hFFFF_FFFF);
    applyStimulus();
    applyStimulus();
    re = 1'b1; raddr = 5'd9;
    #1;
    checkOutput("count_wrap", rdata, 32'h0);

    // Reset while a software interrupt is pending.
    writeReg(5'd13, 32'h0000_0100);
    writeReg(5'd12, 32'h0000_0101);
    pc_valid_i = 1'b1; rst_n = 1'b0;
    applyStimulus();
    checkOutput("rst_flush", flush_o, 1'b0);
    checkOutput("rst_status", status_o, 32'h1000_0000);
    checkOutput("rst_cause", cause_o, 32'h0);
    checkOutput("rst_excaddr", excaddr_o, 32'h0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("post_rst_flush", flush_o, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 Parameter HW_INT_NUM, default 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2].
REQ-002 Parameter COUNT_DIV, default 2, Count increments once per COUNT_DIV clk cycles (1..16).
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0100, target for synchronous exceptions.
REQ-004 Parameter INT_VECTOR, default 32'h0000_0040, target for interrupts.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 we  in  1  MTC0 write strobe; waddr in 5, wdata in 32.
REQ-008 re  in  1  MFC0 read enable; raddr in 5; rdata out 32, combinational, 0 when re=0 or unmapped address.
REQ-009 hw_int_i  in  HW_INT_NUM  level-sensitive external interrupt lines.
REQ-010 exc_valid_i  in  1  synchronous exception at commit; exccode_i in 5; badvaddr_i in 32.
REQ-011 eret_i  in  1  ERET at commit.
REQ-012 pc_i  in 32, in_delay_i  in 1, pc_valid_i  in 1  commit-stage PC, delay-slot flag, PC-valid qualifier.
REQ-013 flush_o  out 1  registered one-cycle pipeline-flush pulse; excaddr_o  out 32  redirect target, valid while flush_o=1.
REQ-014 status_o, cause_o, epc_o  out 32 each  current register values; timer_int_o  out 1  Cause.TI.

Function
REQ-015 Registers: BadVAddr(8, read-only to MTC0), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
REQ-016 Status writable bits: IM[15:8], EXL[1], IE[0]; bit 28 reads 1; all other bits read 0.
REQ-017 Cause writable bits: IP[1:0] (bits 9:8) only; BD bit31, TI bit30, IP[7:2], ExcCode[6:2] hardware-owned.
REQ-018 Cause.IP[7:2] resampled every cycle from hw_int_i (unused lines 0); Cause.IP[7] = hw line 5 OR TI.
REQ-019 Count: prescaler counts 0..COUNT_DIV-1; Count += 1 (mod 2^32) on prescaler wrap; MTC0 Count loads wdata and clears prescaler.
REQ-020 TI set in cycle after Count becomes equal to Compare; held until MTC0 Compare, which clears TI in same edge.
REQ-021 int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM); interrupt taken only when pc_valid_i=1 and exc_valid_i=0.
REQ-022 Event priority per cycle: exception > interrupt > eret > MTC0; lower-priority MTC0 write in same cycle is discarded.
REQ-023 Exception/interrupt with EXL=0: EPC = in_delay_i ? pc_i-4 : pc_i; BD = in_delay_i; with EXL=1: EPC, BD unchanged.
REQ-024 Exception/interrupt: EXL<=1; ExcCode <= exccode_i (exception) or 5'h00 (interrupt).
REQ-025 BadVAddr <= badvaddr_i only for exccode_i 5'h04 (AdEL) or 5'h05 (AdES).
REQ-026 ERET: EXL<=0; excaddr_o = EPC value before that edge.
REQ-027 flush_o asserted exactly one cycle after the triggering edge; excaddr_o = EXC_VECTOR / INT_VECTOR / EPC accordingly; excaddr_o holds last value otherwise.
REQ-028 Read of address written in same cycle returns old value.
REQ-029 Back-to-back events each produce own flush pulse; no event is dropped or merged.

Reset
REQ-030 On rst_n=0: Status=32'h1000_0000, Cause, EPC, BadVAddr, Count, Compare, prescaler=0; TI=0; flush_o=0; excaddr_o=0; rdata=0.
REQ-031 Reset asserted mid-event overrides all pending updates; no flush pulse issued after reset release.

Verification
REQ-032 MTC0 Status=32'h0000_8001, Compare=5, COUNT_DIV=2 -> TI=1 once Count=5 (~11 cycles), then interrupt: flush_o=1, excaddr_o=32'h40, ExcCode=0, EXL=1.
REQ-033 exc_valid_i=1, exccode=5'h04, badvaddr_i=32'hDEAD_BEEF, pc_i=32'h1000, in_delay_i=1 -> EPC=32'h0FFC, BD=1, BadVAddr=32'hDEAD_BEEF, excaddr_o=32'h100.
REQ-034 Nested exception with EXL=1, pc_i=32'h2000 -> EPC unchanged, ExcCode updated, flush_o pulse to 32'h100.
REQ-035 eret_i with EPC=32'h0FFC plus same-cycle MTC0 EPC=32'h1234 -> excaddr_o=32'h0FFC, EPC stays 32'h0FFC, EXL=0.
REQ-036 MTC0 Status=32'hFFFF_FFFF, Cause=32'hFFFF_FFFF -> read Status=32'h1000_FF03, Cause bits 9:8 set, other writable-masked bits unchanged.
REQ-037 Count=32'hFFFF_FFFF with prescaler wrap -> Count=0; rst_n low during pending interrupt -> all outputs at reset values, no flush.
